// File: rtl/median_window_gen.sv
// Raster-to-3x3 window generator feeding the median stage: two line buffers plus a 3x3 shift window.
// Optional sticky frame-error flag o_frame_err when MEDIAN_WINDOW_GEN_FRAME_ERR_EN is defined.
module median_window_gen #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic [7:0]  i_pixel,
  input  logic        i_pixel_valid,
  input  logic        i_sof,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_frame_done
`ifdef MEDIAN_WINDOW_GEN_FRAME_ERR_EN
  ,
  output logic        o_frame_err
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   col;
  logic [CW-1:0]   cur_col;
  logic [RW-1:0]   row;
  logic [RW-1:0]   cur_row;
  logic            start;
  logic            accept;
  logic            line_end;
  logic            frame_end;
  logic            frame_last;
  logic            window_ok;
  logic [7:0]      lb0 [IMG_WIDTH];
  logic [7:0]      lb1 [IMG_WIDTH];
  logic [7:0]      up1;
  logic [7:0]      up2;
  logic [71:0]     win;
  logic [71:0]     win_next;

  // A start-of-frame pixel always lands at (0,0), whatever the counters hold.
  assign start     = i_pixel_valid && i_sof;
  assign cur_col   = start ? '0 : col;
  assign cur_row   = start ? '0 : row;
  assign line_end  = (cur_col == CW'(IMG_WIDTH - 1));
  assign frame_end = line_end && (cur_row == RW'(IMG_HEIGHT - 1));

  always_ff @(posedge i_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = FILL;
      FILL: begin
        if (start)
          state_next = FILL;
        else if (accept && line_end && cur_row == RW'(1))
          state_next = RUN;
      end
      RUN: begin
        if (start)
          state_next = FILL;
        else if (accept && frame_end)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept     = i_pixel_valid && (i_sof || state != IDLE);
    frame_last = accept && !start && (state == RUN) && frame_end;
    window_ok  = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (line_end) begin
        col <= '0;
        row <= frame_end ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // Line buffers are read-before-write on the same column: lb0 holds line r-1, lb1 line r-2.
  assign up1 = lb0[cur_col];
  assign up2 = lb1[cur_col];

  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb1[cur_col] <= up1;
      lb0[cur_col] <= i_pixel;
    end
  end

  // Byte k of the window is row k/3, col k%3; each row shifts left and the new column enters at col 2.
  assign win_next = {i_pixel, win[71:64], win[63:56],
                     up1,     win[47:40], win[39:32],
                     up2,     win[23:16], win[15:8]};

  always_ff @(posedge i_clk) begin
    if (rst) begin
      win                <= '0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_frame_done       <= 1'b0;
    end else begin
      o_pixel_data_valid <= window_ok;
      o_frame_done       <= frame_last;
      if (accept)
        win <= win_next;
      if (window_ok)
        o_pixel_data <= win_next;
    end
  end

`ifdef MEDIAN_WINDOW_GEN_FRAME_ERR_EN
  // Sticky: aborted frames and pixels dropped while waiting for a start both count as errors.
  always_ff @(posedge i_clk) begin
    if (rst)
      o_frame_err <= 1'b0;
    else if ((start && state != IDLE) || (i_pixel_valid && !i_sof && state == IDLE))
      o_frame_err <= 1'b1;
  end
`endif

endmodule
